// File: rtl/voice_env_sequencer.sv
// Frame slot sequencer for the voice/osc/envelope pipeline: sweeps the
// {voice, osc, env} slot counter, then drains the strobe and delay lines.
module voice_env_sequencer #(
    parameter int VOICES       = 8,
    parameter int V_OSC        = 4,
    parameter int O_ENVS       = 2,
    parameter int FLUSH_CYCLES = 16,
    parameter int V_WIDTH      = $clog2(VOICES),
    parameter int O_WIDTH      = $clog2(V_OSC),
    parameter int OE_WIDTH     = $clog2(O_ENVS),
    parameter int E_WIDTH      = O_WIDTH + OE_WIDTH,
    parameter int V_ENVS       = V_OSC * O_ENVS,
    parameter int x_offset     = (V_OSC * VOICES) - 2
) (
    input  logic                                sCLK_XVXENVS,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                sample_tick,
    input  logic                                overrun_clr,
    output logic [V_WIDTH+E_WIDTH-1:0]          xxxx,
    output logic [V_WIDTH-1:0]                  vx,
    output logic [O_WIDTH-1:0]                  ox,
    output logic [OE_WIDTH-1:0]                 ex,
    output logic [x_offset:0][O_WIDTH-1:0]      ox_dly,
    output logic [V_OSC+2:0]                    sh_voice_reg,
    output logic [V_ENVS:0]                     sh_osc_reg,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                overrun
);

    localparam int XW = V_WIDTH + E_WIDTH;
    localparam int N  = VOICES * V_ENVS;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XW-1:0]     xxxx_next;
    logic [FW-1:0]     flush_cnt;
    logic [FW-1:0]     flush_next;
    logic              overrun_next;
    logic              flush_last;

    logic [V_ENVS:1]                osc_q;
    logic [V_OSC+2:1]               voice_q;
    logic [x_offset:1][O_WIDTH-1:0] ox_q;

    assign vx = xxxx[XW-1:E_WIDTH];
    assign ox = xxxx[E_WIDTH-1:OE_WIDTH];
    assign ex = xxxx[OE_WIDTH-1:0];

    assign busy       = (state != IDLE);
    assign flush_last = (flush_cnt == FW'(FLUSH_CYCLES - 1));
    assign frame_done = (state == FLUSH) && flush_last;

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            state     <= IDLE;
            xxxx      <= '0;
            flush_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            xxxx      <= xxxx_next;
            flush_cnt <= flush_next;
            overrun   <= overrun_next;
        end
    end

    always_comb begin
        state_next = state;
        xxxx_next  = '0;
        flush_next = '0;
        unique case (state)
            IDLE: begin
                if (sample_tick && enable) state_next = SWEEP;
            end
            SWEEP: begin
                if (xxxx == XW'(N - 1)) state_next = FLUSH;
                else xxxx_next = xxxx + 1'b1;
            end
            FLUSH: begin
                if (flush_last) state_next = IDLE;
                else flush_next = flush_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A tick during a busy frame is dropped; its flag beats a same-cycle clear.
    always_comb begin
        overrun_next = overrun;
        if (sample_tick && busy) overrun_next = 1'b1;
        else if (overrun_clr) overrun_next = 1'b0;
    end

    assign sh_osc_reg   = {osc_q, (state == SWEEP) && (ex == '0)};
    assign sh_voice_reg = {voice_q, (state == SWEEP) && (ox == '0) && (ex == '0)};
    assign ox_dly       = {ox_q, ox};

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            osc_q   <= '0;
            voice_q <= '0;
            ox_q    <= '0;
        end else begin
            osc_q   <= sh_osc_reg[V_ENVS-1:0];
            voice_q <= sh_voice_reg[V_OSC+1:0];
            ox_q    <= ox_dly[x_offset-1:0];
        end
    end

endmodule

// File: tb/tb_voice_env_sequencer.sv
// Randomized bench for voice_env_sequencer against a frame-timeline model
// that derives every output from the cycle a tick was accepted.
module tb_voice_env_sequencer;

    localparam int VOICES = 8;
    localparam int V_OSC  = 4;
    localparam int O_ENVS = 2;
    localparam int F      = 16;
    localparam int V_ENVS = V_OSC * O_ENVS;
    localparam int N      = VOICES * V_ENVS;
    localparam int XO     = V_OSC * VOICES - 2;
    localparam int OW     = 2;
    localparam int MAXC   = 8000;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enable = 1'b1;
    logic                    sample_tick = 1'b0;
    logic                    overrun_clr = 1'b0;
    logic [5:0]              xxxx;
    logic [2:0]              vx;
    logic [1:0]              ox;
    logic [0:0]              ex;
    logic [XO:0][OW-1:0]     ox_dly;
    logic [V_OSC+2:0]        sh_voice_reg;
    logic [V_ENVS:0]         sh_osc_reg;
    logic                    busy;
    logic                    frame_done;
    logic                    overrun;

    voice_env_sequencer dut (
        .sCLK_XVXENVS (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .overrun_clr  (overrun_clr),
        .xxxx         (xxxx),
        .vx           (vx),
        .ox           (ox),
        .ex           (ex),
        .ox_dly       (ox_dly),
        .sh_voice_reg (sh_voice_reg),
        .sh_osc_reg   (sh_osc_reg),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_acc  = -1000;
    int rst_c  = -1;
    bit m_ovr  = 1'b0;
    int xh [0:MAXC-1];
    bit swh[0:MAXC-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    function automatic bit osc0(input int j);
        return swh[j] && (xh[j] % O_ENVS == 0);
    endfunction

    function automatic bit voice0(input int j);
        return swh[j] && (xh[j] % V_ENVS == 0);
    endfunction

    function automatic int ox_of(input int j);
        return (xh[j] / O_ENVS) % V_OSC;
    endfunction

    task automatic check_outputs(input int c);
        int d, x;
        bit sw, bz;
        logic [63:0] eo, ev, ed;
        d  = c - t_acc;
        sw = (d >= 1) && (d <= N);
        bz = (d >= 1) && (d <= N + F);
        x  = sw ? d - 1 : 0;
        xh[c]  = x;
        swh[c] = sw;
        chk("xxxx", xxxx, x);
        chk("vx", vx, x / V_ENVS);
        chk("ox", ox, (x / O_ENVS) % V_OSC);
        chk("ex", ex, x % O_ENVS);
        chk("busy", busy, bz);
        chk("frame_done", frame_done, d == N + F);
        chk("overrun", overrun, m_ovr);
        eo = '0;
        ev = '0;
        ed = '0;
        for (int k = 0; k <= V_ENVS; k++)
            if (k == 0 || c - k > rst_c) eo[k] = osc0(c - k);
        for (int k = 0; k <= V_OSC + 2; k++)
            if (k == 0 || c - k > rst_c) ev[k] = voice0(c - k);
        for (int k = 0; k <= XO; k++)
            if (k == 0 || c - k > rst_c) ed[k*OW +: OW] = OW'(ox_of(c - k));
        chk("sh_osc_reg", sh_osc_reg, eo);
        chk("sh_voice_reg", sh_voice_reg, ev);
        chk("ox_dly", ox_dly, ed);
        if (c == 74) chk("first_last_slot", xxxx, 63);
        if (c == 90) chk("first_done", frame_done, 1);
        if (c == 91) chk("first_idle", busy, 0);
    endtask

    task automatic model_update(input int c, input bit r, input bit tk,
                                input bit en, input bit cl);
        int d;
        bit bz;
        d  = c - t_acc;
        bz = (d >= 1) && (d <= N + F);
        if (r) begin
            t_acc = -1000;
            m_ovr = 1'b0;
            rst_c = c;
        end else begin
            if (tk && bz) m_ovr = 1'b1;
            else if (cl) m_ovr = 1'b0;
            if (tk && !bz && en) t_acc = c;
        end
    endtask

    task automatic step(input bit r, input bit tk, input bit en, input bit cl);
        @(negedge clk);
        check_outputs(cyc);
        reset       = r;
        sample_tick = tk;
        enable      = en;
        overrun_clr = cl;
        model_update(cyc, r, tk, en, cl);
        cyc++;
    endtask

    initial begin
        @(posedge clk);
        repeat (3) step(1, 0, 1, 0);
        while (cyc < 10) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        repeat (100) step(0, 0, 1, 0);

        for (int i = 0; i <= N + F + 3; i++)
            step(0, i == 0 || i == 10 || i == N + F, 1, 0);
        step(0, 0, 1, 1);
        repeat (3) step(0, 0, 1, 0);

        for (int i = 0; i <= N + F + 2; i++)
            step(0, i == 0 || i == 5, 1, i == 5);
        repeat (40) step(0, 0, 1, 0);
        step(0, 0, 1, 1);

        step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        for (int i = 0; i <= N + F + 2; i++)
            step(0, i == 0, i < 31, 0);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        for (int i = 0; i <= 41; i++)
            step(i == 41, i == 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        repeat (N + F + 40) step(0, 0, 1, 0);

        repeat (3000)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0);
        repeat (120) step(0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
